// File: rtl/trap_csr_unit.sv
// Machine-mode trap CSR file and fetch redirect generator.
// Optional 64-bit mcycle counter at 0xB00/0xB80 when TRAP_CSR_COUNTERS_EN is defined.
module trap_csr_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trapEnter,
    input  logic [3:0]  trapCause,
    input  logic [31:0] trapValue,
    input  logic [31:0] trapPc,
    input  logic        mretSignal,
    input  logic        csrValid,
    input  logic [11:0] csrAddress,
    input  logic [1:0]  csrOp,
    input  logic [31:0] csrWriteSource,
    input  logic        csrWriteSuppress,
    output logic [31:0] csrReadData,
    output logic        csrIllegal,
    output logic        redirectValid,
    output logic [31:0] redirectPc,
    output logic        mieBit
);
    localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10;

    typedef enum logic {IDLE, REDIRECT} state_t;
    state_t r_state;

    logic        r_mie, r_mpie;
    logic [29:0] r_mtvec, r_mepc;
    logic [31:0] r_mscratch, r_mtval;
    logic [3:0]  r_mcause;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
`ifdef TRAP_CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
`endif

    logic        w_wr_intent, w_known, w_wr_en;
    logic [31:0] w_old, w_new;

    // RS/RC with a zero source field is a pure read and never writes.
    assign w_wr_intent = (csrOp != OP_NONE) && !(csrWriteSuppress && (csrOp != OP_RW));

    always_comb begin
        w_known = 1'b1;
        w_old   = 32'h0;
        case (csrAddress)
            12'h300: w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            12'h301: w_old = MISA_VALUE;
            12'h305: w_old = {r_mtvec, 2'b00};
            12'h340: w_old = r_mscratch;
            12'h341: w_old = {r_mepc, 2'b00};
            12'h342: w_old = {28'b0, r_mcause};
            12'h343: w_old = r_mtval;
`ifdef TRAP_CSR_COUNTERS_EN
            12'hB00: w_old = r_mcycle[31:0];
            12'hB80: w_old = r_mcycle[63:32];
`endif
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        case (csrOp)
            OP_RW:   w_new = csrWriteSource;
            OP_RS:   w_new = w_old | csrWriteSource;
            default: w_new = w_old & ~csrWriteSource;
        endcase
    end

    assign csrReadData = w_old;
    assign csrIllegal  = !w_known || ((csrAddress == 12'h301) && w_wr_intent);
    assign w_wr_en     = csrValid && w_wr_intent && !csrIllegal && !trapEnter && !mretSignal;

    assign redirectValid = r_redirect_valid;
    assign redirectPc    = r_redirect_pc;
    assign mieBit        = r_mie;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
            r_mtvec          <= RESET_MTVEC[31:2];
            r_mepc           <= 30'h0;
            r_mscratch       <= 32'h0;
            r_mtval          <= 32'h0;
            r_mcause         <= 4'h0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
        end else begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
            if (trapEnter) begin
                r_mepc           <= trapPc[31:2];
                r_mcause         <= trapCause;
                r_mtval          <= trapValue;
                r_mpie           <= r_mie;
                r_mie            <= 1'b0;
                r_state          <= REDIRECT;
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= {r_mtvec, 2'b00};
            end else if (mretSignal) begin
                r_mie            <= r_mpie;
                r_mpie           <= 1'b1;
                r_state          <= REDIRECT;
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= {r_mepc, 2'b00};
            end else if (w_wr_en) begin
                case (csrAddress)
                    12'h300: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    12'h305: r_mtvec    <= w_new[31:2];
                    12'h340: r_mscratch <= w_new;
                    12'h341: r_mepc     <= w_new[31:2];
                    12'h342: r_mcause   <= w_new[3:0];
                    12'h343: r_mtval    <= w_new;
                    default: ;
                endcase
            end
        end
    end

`ifdef TRAP_CSR_COUNTERS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_mcycle <= 64'h0;
        else if (w_wr_en && csrAddress == 12'hB00)
            r_mcycle[31:0] <= w_new;
        else if (w_wr_en && csrAddress == 12'hB80)
            r_mcycle[63:32] <= w_new;
        else
            r_mcycle <= r_mcycle + 64'h1;
    end
`endif

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap responder: consumes the hazard unit's trap outputs (controlReset, mcause, mtval) and mretSignal.
- Holds the M-mode trap CSRs and services CSR instructions from the writeback stage.
- Issues the one-cycle PC redirect to fetch on trap entry and on mret.
- Sits beside the writeback stage; its redirect drives the fetch PC mux.

Parameters:
- RESET_MTVEC, 32'h0000_0000: mtvec reset value; the trap target is 0 unless software rewrites mtvec.
- MISA_VALUE, 32'h4000_0100: read-only misa contents (RV32I).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- trapEnter  in  1  trap commit pulse (hazard controlReset).
- trapCause  in  4  exception code (hazard mcause).
- trapValue  in  32  faulting address/value (hazard mtval).
- trapPc  in  32  PC of the trapping instruction in MEM/WB.
- mretSignal  in  1  mret committing in writeback.
- csrValid  in  1  CSR instruction committing this cycle.
- csrAddress  in  12  CSR number.
- csrOp  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csrWriteSource  in  32  rs1 value or zero-extended uimm.
- csrWriteSuppress  in  1  rs1/uimm field is x0/0; no write for RS/RC.
- csrReadData  out  32  combinational old value of the addressed CSR.
- csrIllegal  out  1  combinational; unimplemented address or write to read-only CSR.
- redirectValid  out  1  registered one-cycle redirect pulse.
- redirectPc  out  32  redirect target; valid only with redirectValid.
- mieBit  out  1  mstatus.MIE, for a future interrupt block.

Behaviour:
- Reset (reset low, asynchronous):
  - mstatus = 32'h0000_1800: MPP=11, MIE=0, MPIE=0.
  - mtvec = RESET_MTVEC; mscratch, mepc, mcause, mtval = 0.
  - FSM = IDLE; redirectValid = 0; redirectPc = 0.
- CSR map:
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; MPP (bits 12:11) reads 11; all other bits read 0.
  - 0x301 misa: returns MISA_VALUE. An RW write is illegal; RS/RC with csrWriteSuppress=1 is legal and performs no write.
  - 0x305 mtvec: bits 1:0 forced to 00 (direct mode).
  - 0x340 mscratch: full 32-bit read/write.
  - 0x341 mepc: bits 1:0 forced to 0.
  - 0x342 mcause: bit 31 reads 0; bits 3:0 writable; all other bits read 0.
  - 0x343 mtval: full 32-bit read/write.
  - Any other address: csrIllegal=1, csrReadData=0.
- CSR write:
  - Commits at the clock edge when csrValid=1, csrOp!=00, csrIllegal=0, and not (csrWriteSuppress=1 with csrOp RS/RC).
  - RW writes src; RS writes old | src; RC writes old & ~src.
  - Reads are combinational and return the pre-write value.
- FSM states: IDLE, REDIRECT.
- Trap entry (trapEnter=1, any state), updated at the edge:
  - mepc = {trapPc[31:2], 2'b00}; mcause = {28'b0, trapCause}; mtval = trapValue.
  - MPIE = MIE, then MIE = 0.
  - Next cycle: FSM = REDIRECT, redirectValid = 1, redirectPc = {mtvec[31:2], 2'b00}. Latency is exactly 1 cycle.
- mret (mretSignal=1, trapEnter=0), updated at the edge:
  - MIE = MPIE, MPIE = 1.
  - Next cycle: redirectValid = 1, redirectPc = mepc as held before that edge.
- REDIRECT lasts exactly one cycle, then returns to IDLE unless a new trapEnter or mret arrives, in which case it re-enters REDIRECT with the new target.
- Simultaneous-event priority:
  - trapEnter > mretSignal > CSR write.
  - A CSR write in the same cycle as trapEnter or mret is dropped entirely.
  - csrReadData still reflects the old value.
- A trap during REDIRECT is accepted normally; the newest target wins.
- Reset asserted mid-REDIRECT clears redirectValid immediately (asynchronous).

Optional Feature:
- Macro: TRAP_CSR_COUNTERS_EN.
- Defined: adds a 64-bit mcycle counter.
  - Increments every cycle out of reset and wraps 2^64-1 -> 0.
  - Readable/writable at 0xB00 (low half) and 0xB80 (high half).
  - A CSR write to either half that cycle replaces that half; the increment is suppressed that cycle.
  - Reset value 0.
- Not defined: 0xB00 and 0xB80 behave as unimplemented (csrIllegal=1), and no counter logic exists.

Test Plan:
- Reset, then read 0x300, 0x305, 0x301 -> 32'h0000_1800, RESET_MTVEC, MISA_VALUE; redirectValid=0.
- RW 0x305 with 0x8000_0103, then trapEnter with cause 4'h2, pc 0x0000_0046, value 0xDEAD_BEEF -> next cycle redirectValid=1 and redirectPc=0x8000_0100; mepc=0x44, mcause=2, mtval=0xDEADBEEF.
- Set MIE via RS 0x300 src 0x8, then trap, then mret -> after trap MIE=0, MPIE=1; after mret MIE=1, MPIE=1; redirectPc=0x44 one cycle after mret.
- Same cycle: trapEnter=1, mretSignal=1, and csrValid RW 0x340 with 0x1234 -> trap target issued, mscratch stays 0, mepc updated.
- RW to 0x301 and read of 0x7C0 -> csrIllegal=1, no state change; RS 0x301 with csrWriteSuppress=1 -> csrIllegal=0.
- With TRAP_CSR_COUNTERS_EN: write 0xB00 = 0xFFFF_FFFF, 0xB80 = 0 -> two cycles later 0xB80 reads 1 (low-half carry). Without the macro: 0xB00 gives csrIllegal=1.
